// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream handshake bundle feeding the instruction loader
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    // Byte source side: drives data/valid, observes ready.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    // Loader side: consumes data/valid, drives ready.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction loader with XOR checksum and fetch port
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    imem_loader_if.slave      rx,
    input  logic              restart,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [7:0]        fetch_instr,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   prog_len
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [7:0]        csum;
    logic [7:0]        csum_nxt;
    logic [LEN_W-1:0]  prog_len_nxt;
    logic              core_reset_nxt;
    logic              load_done_nxt;
    logic              load_error_nxt;
    logic              mem_we;
    logic              fire;
    logic              len_ok;
    logic              last_instr;

    logic [7:0] mem [DEPTH];

    // Ready is decoded from state only, so a source may hold valid without a combinational loop.
    assign rx.rx_ready = !reset && ((state == IDLE) || (state == LOAD) || (state == CHECK));
    assign fire        = rx.rx_valid && rx.rx_ready;

    // Length byte must lie in 1..DEPTH; compared at 9 bits so DEPTH = 256 still works.
    assign len_ok      = (rx.rx_data != 8'h00) && ({1'b0, rx.rx_data} <= 9'(DEPTH));

    // Index of the final instruction byte, i.e. the one after which the checksum follows.
    assign last_instr  = ({1'b0, idx} == (prog_len - LEN_W'(1)));

    // State and status register update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            csum       <= '0;
            prog_len   <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            csum       <= csum_nxt;
            prog_len   <= prog_len_nxt;
            core_reset <= core_reset_nxt;
            load_done  <= load_done_nxt;
            load_error <= load_error_nxt;
        end
    end

    // Next-state, checksum accumulation and memory write enable; restart overrides everything.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        csum_nxt       = csum;
        prog_len_nxt   = prog_len;
        core_reset_nxt = core_reset;
        load_done_nxt  = load_done;
        load_error_nxt = load_error;
        mem_we         = 1'b0;

        if (restart) begin
            // Any byte handshaken in this cycle is swallowed without a write.
            state_nxt      = IDLE;
            idx_nxt        = '0;
            csum_nxt       = '0;
            prog_len_nxt   = '0;
            core_reset_nxt = 1'b1;
            load_done_nxt  = 1'b0;
            load_error_nxt = 1'b0;
        end else if (fire) begin
            case (state)
                IDLE: begin
                    if (len_ok) begin
                        prog_len_nxt = LEN_W'(rx.rx_data);
                        idx_nxt      = '0;
                        csum_nxt     = rx.rx_data;
                        state_nxt    = LOAD;
                    end else begin
                        state_nxt      = ERROR;
                        load_error_nxt = 1'b1;
                        core_reset_nxt = 1'b1;
                    end
                end
                LOAD: begin
                    mem_we   = 1'b1;
                    csum_nxt = csum ^ rx.rx_data;
                    idx_nxt  = idx + ADDR_W'(1);
                    if (last_instr) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (rx.rx_data == csum) begin
                        state_nxt      = DONE;
                        core_reset_nxt = 1'b0;
                        load_done_nxt  = 1'b1;
                    end else begin
                        state_nxt      = ERROR;
                        core_reset_nxt = 1'b1;
                        load_error_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Instruction memory: cleared only by reset, survives restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem[idx] <= rx.rx_data;
        end
    end

    // Fetch port: addresses beyond the loaded program read as zero.
    always_comb begin
        fetch_instr = 8'h00;
        if ({1'b0, fetch_addr} < prog_len) begin
            fetch_instr = mem[fetch_addr];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic       clock;
    logic       reset;
    logic       restart;
    logic [4:0] fetch_addr;
    logic [7:0] fetch_instr;
    logic       core_reset;
    logic       load_done;
    logic       load_error;
    logic [5:0] prog_len;

    int n_cmp;
    int n_err;

    imem_loader_if rxif ();

    imem_loader #(.ADDR_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rxif.slave),
        .restart     (restart),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .load_error  (load_error),
        .prog_len    (prog_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the loader takes it (bounded).
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        rxif.rx_data  = b;
        rxif.rx_valid = 1'b1;
        while (!rxif.rx_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("send_ready", 32'(rxif.rx_ready), 32'd1);
        @(posedge clock);
        #1;
        rxif.rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
    endtask

    task automatic fetch_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        @(negedge clock);
        fetch_addr = a;
        #1;
        check(tag, 32'(fetch_instr), 32'(exp));
    endtask

    logic [7:0] sum;

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        restart       = 1'b0;
        rxif.rx_data  = 8'h00;
        rxif.rx_valid = 1'b0;
        fetch_addr    = '0;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_rx_ready",   32'(rxif.rx_ready), 32'd0);
        check("rst_core_reset", 32'(core_reset),    32'd1);
        check("rst_load_done",  32'(load_done),     32'd0);
        check("rst_load_error", 32'(load_error),    32'd0);
        check("rst_prog_len",   32'(prog_len),      32'd0);
        check("rst_fetch",      32'(fetch_instr),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(rxif.rx_ready), 32'd1);

        // Basic 3-instruction program
        send(8'h03);
        send(8'h41);
        send(8'h8A);
        send(8'hC3);
        check("pre_csum_core_reset", 32'(core_reset), 32'd1);
        send(8'h0B);
        check("ok_core_reset", 32'(core_reset),    32'd0);
        check("ok_load_done",  32'(load_done),     32'd1);
        check("ok_prog_len",   32'(prog_len),      32'd3);
        check("ok_rx_ready",   32'(rxif.rx_ready), 32'd0);
        fetch_chk("ok_f0",  5'd0,  8'h41);
        fetch_chk("ok_f1",  5'd1,  8'h8A);
        fetch_chk("ok_f2",  5'd2,  8'hC3);
        fetch_chk("ok_f3",  5'd3,  8'h00);
        fetch_chk("ok_f31", 5'd31, 8'h00);

        // Bad checksum
        pulse_restart();
        check("rs_core_reset", 32'(core_reset), 32'd1);
        check("rs_load_done",  32'(load_done),  32'd0);
        send(8'h03);
        send(8'h41);
        send(8'h8A);
        send(8'hC3);
        send(8'h0C);
        check("bad_load_error", 32'(load_error),    32'd1);
        check("bad_core_reset", 32'(core_reset),    32'd1);
        check("bad_rx_ready",   32'(rxif.rx_ready), 32'd0);
        check("bad_load_done",  32'(load_done),     32'd0);
        pulse_restart();
        check("bad_rs_ready",   32'(rxif.rx_ready), 32'd1);
        check("bad_rs_error",   32'(load_error),    32'd0);
        check("bad_rs_len",     32'(prog_len),      32'd0);
        fetch_chk("bad_rs_f0", 5'd0, 8'h00);

        // Illegal length bytes
        send(8'h00);
        check("len0_error", 32'(load_error),    32'd1);
        check("len0_len",   32'(prog_len),      32'd0);
        check("len0_ready", 32'(rxif.rx_ready), 32'd0);
        pulse_restart();
        send(8'h21);
        check("len33_error", 32'(load_error),    32'd1);
        check("len33_len",   32'(prog_len),      32'd0);
        check("len33_ready", 32'(rxif.rx_ready), 32'd0);
        pulse_restart();

        // Full-depth load with an idle cycle after every byte
        sum = 8'h20;
        send(8'h20);
        @(posedge clock);
        for (int i = 0; i < 32; i++) begin
            send(8'(i) ^ 8'h5A);
            sum = sum ^ (8'(i) ^ 8'h5A);
            @(posedge clock);
        end
        #1;
        check("full_not_done", 32'(load_done),     32'd0);
        check("full_in_check", 32'(rxif.rx_ready), 32'd1);
        send(sum);
        check("full_done",     32'(load_done),  32'd1);
        check("full_prog_len", 32'(prog_len),   32'd32);
        check("full_core_rst", 32'(core_reset), 32'd0);
        for (int i = 0; i < 32; i++) begin
            fetch_chk("full_fetch", 5'(i), 8'(i) ^ 8'h5A);
        end

        // Reset mid-load
        pulse_restart();
        send(8'h03);
        send(8'h11);
        send(8'h22);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rx_ready",   32'(rxif.rx_ready), 32'd0);
        check("mid_core_reset", 32'(core_reset),    32'd1);
        check("mid_load_done",  32'(load_done),     32'd0);
        check("mid_load_error", 32'(load_error),    32'd0);
        check("mid_prog_len",   32'(prog_len),      32'd0);
        check("mid_fetch",      32'(fetch_instr),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        send(8'h04);
        send(8'hAB);
        fetch_chk("clr_f0", 5'd0, 8'hAB);
        fetch_chk("clr_f1", 5'd1, 8'h00);
        fetch_chk("clr_f2", 5'd2, 8'h00);
        fetch_chk("clr_f3", 5'd3, 8'h00);
        send(8'hCD);
        send(8'hEF);
        send(8'h12);
        send(8'h9F);
        check("clean_done", 32'(load_done), 32'd1);
        check("clean_len",  32'(prog_len),  32'd4);
        fetch_chk("clean_f3", 5'd3, 8'h12);

        // Restart coinciding with a LOAD handshake
        pulse_restart();
        send(8'h03);
        send(8'h55);
        @(negedge clock);
        rxif.rx_data  = 8'hFF;
        rxif.rx_valid = 1'b1;
        restart       = 1'b1;
        @(posedge clock);
        #1;
        rxif.rx_valid = 1'b0;
        restart       = 1'b0;
        check("co_ready",      32'(rxif.rx_ready), 32'd1);
        check("co_prog_len",   32'(prog_len),      32'd0);
        check("co_core_reset", 32'(core_reset),    32'd1);
        send(8'h02);
        fetch_chk("co_f0", 5'd0, 8'h55);
        fetch_chk("co_f1", 5'd1, 8'hCD);
        send(8'h66);
        send(8'h77);
        send(8'h13);
        check("co_done", 32'(load_done), 32'd1);
        fetch_chk("co_g0", 5'd0, 8'h66);
        fetch_chk("co_g1", 5'd1, 8'h77);
        fetch_chk("co_g2", 5'd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader sitting directly upstream of the 4-stage pipelined datapath. Receives a program as a byte stream over a valid/ready handshake, writes it into an on-chip 8-bit instruction memory, and verifies an XOR checksum. It holds the datapath in reset until a verified load completes. It then serves instruction fetches to the IF stage from that memory.

## Interface
- `ADDR_W`, default 5: instruction address width; memory depth `DEPTH = 2**ADDR_W` (max 256).
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and memory.
- `rx_data`  in  8: incoming stream byte.
- `rx_valid`  in  1: `rx_data` valid.
- `rx_ready`  out  1: loader can accept a byte; a transfer occurs when `rx_valid && rx_ready` on a clock edge.
- `restart`  in  1: synchronous request to return to IDLE and await a new program.
- `fetch_addr`  in  ADDR_W: IF-stage instruction address.
- `fetch_instr`  out  8: instruction at `fetch_addr`, combinational read.
- `core_reset`  out  1: drives the datapath `reset`; high until a verified load completes.
- `load_done`  out  1: verified program resident.
- `load_error`  out  1: load rejected.
- `prog_len`  out  ADDR_W+1: number of valid instructions loaded.

## Operation
- Stream format:
  - One length byte N (legal range 1..DEPTH).
  - Then N instruction bytes, written to addresses 0..N-1.
  - Then one checksum byte equal to the XOR of the length byte and all N instruction bytes.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- IDLE:
  - On accepting a byte with 1 ≤ byte ≤ DEPTH: `prog_len` ← byte, write index ← 0, running checksum ← byte, go to LOAD.
  - On accepting a byte of 0 or > DEPTH: `prog_len` stays 0, go to ERROR.
- LOAD:
  - Each accepted byte is written to `mem[index]`, XORed into the checksum, and increments the index.
  - Accepting the byte at index N-1 moves to CHECK.
- CHECK:
  - Accepted byte equal to the running checksum → DONE.
  - Otherwise → ERROR.
- DONE: `core_reset` = 0, `load_done` = 1. No further bytes accepted.
- ERROR: `load_error` = 1, `core_reset` = 1. No further bytes accepted.
- `restart` high in any state:
  - Next state IDLE; `prog_len` ← 0; `load_done`/`load_error` ← 0; `core_reset` ← 1.
  - A byte handshaken in the same cycle is consumed and discarded (no memory write).
  - `restart` has priority over every other transition.
- Memory contents persist across `restart`. Only `reset` zeroes them.
- Fetch rule:
  - `fetch_instr = mem[fetch_addr]` if `fetch_addr < prog_len`, else 8'h00.
  - `prog_len` is ADDR_W+1 bits, so N = DEPTH is representable and every address is valid.
- `rx_ready = !reset && state ∈ {IDLE, LOAD, CHECK}`. Purely state-decoded; no dependency on `rx_valid`.
- `rx_valid` may drop between bytes for any number of cycles. State and index hold while no handshake occurs.

## Timing
- Reset values (asserted asynchronously):
  - Outputs: `rx_ready` = 0, `core_reset` = 1, `load_done` = 0, `load_error` = 0, `prog_len` = 0, `fetch_instr` = 8'h00.
  - Internal: state IDLE, all memory entries 8'h00.
- After reset deasserts, `rx_ready` = 1 in the first cycle.
- Throughput: one byte per cycle. A program of N instructions needs N+2 cycles minimum.
- Memory write is visible on `fetch_instr` the cycle after the write edge.
- `core_reset`, `load_done`, `load_error` are registered. They change on the edge that accepts the checksum byte, or on the edge sampling `restart`.
- On the DONE transition:
  - `core_reset` falls on the same edge that accepts the checksum byte.
  - The datapath fetches address 0 starting on the next edge.
- `reset` asserted mid-LOAD or mid-CHECK: immediate return to reset values. The partial program is lost.

## Test plan
- Reset, then stream 8'h03, 8'h41, 8'h8A, 8'hC3, 8'h0B back-to-back:
  - `core_reset` falls and `load_done` = 1 after the 5th handshake; `prog_len` = 3.
  - Fetches return 0→41, 1→8A, 2→C3, 3→00, 31→00.
- Same stream with checksum 8'h0C:
  - `load_error` = 1, `core_reset` stays 1, `rx_ready` = 0.
  - Then `restart` pulse → IDLE, `rx_ready` = 1, `load_error` = 0, `prog_len` = 0.
- Length byte 8'h00, and separately 8'h21 (DEPTH = 32):
  - Each → ERROR after 1 handshake; `prog_len` = 0; no memory write.
- Full-depth load of N = 32 bytes `i ^ 8'h5A` with `rx_valid` toggling every other cycle:
  - Index advances only on handshakes; `prog_len` = 32; all 32 fetches match.
- Assert `reset` after 2 of 3 instruction bytes:
  - All outputs at reset values immediately; memory reads 8'h00.
  - A subsequent clean load completes normally.
- `restart` coincident with a LOAD handshake of 8'hFF:
  - Byte discarded, `mem[index]` unchanged, state IDLE next cycle.
